// File: rtl/frame_reader_pkg.sv
// Shared constants for the frame reader: control characters, the printable
// range used by the sanitizer, and the FSM state encoding.
package frame_reader_pkg;

    // Characters emitted or substituted by the reader.
    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] LF       = 8'h0A;
    localparam logic [7:0] DOT      = 8'h2E;
    localparam logic [7:0] TILDE    = 8'h7E;

    // Inclusive printable range; anything outside becomes DOT.
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    // FSM state encoding.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_SEND_CH = 3'd2;
    localparam logic [2:0] ST_SEND_CR = 3'd3;
    localparam logic [2:0] ST_SEND_LF = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/frame_reader.sv
// Frame reader: walks a ROWS x COLS character buffer and streams it out as
// text, one byte per valid/ready transfer, with CR LF closing every row.
//
// Handshake: a byte moves on any rising edge where tx_valid=1 and
// tx_ready=1. Once tx_valid rises it stays high, with tx_data unchanged,
// until that transfer happens; tx_ready is ignored while tx_valid=0.
module frame_reader
    import frame_reader_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state
);

    // Counter limits narrowed to the counter width; ROWS*COLS <= 256 keeps them in range.
    localparam logic [7:0] COLS_W   = 8'(COLS);
    localparam logic [7:0] LAST_COL = 8'(COLS - 1);
    localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] row_q, row_d;
    logic [7:0] col_q, col_d;
    logic [7:0] tx_data_q, tx_data_d;

    logic [7:0] fetch_addr;
    logic [7:0] clean_byte;
    logic       xfer;

    // Linear buffer address of the current cell; never exceeds ROWS*COLS-1.
    always_comb begin
        fetch_addr = row_q * COLS_W + col_q;
    end

    // Sanitizer: printable bytes pass through, everything else becomes '.'.
    always_comb begin
        if (rd_data >= PRINT_LO && rd_data <= PRINT_HI) begin
            clean_byte = rd_data;
        end else begin
            clean_byte = DOT;
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        tx_valid  = (state_q == ST_SEND_CH) || (state_q == ST_SEND_CR) ||
                    (state_q == ST_SEND_LF);
        busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done      = (state_q == ST_DONE);
        rd_addr   = (state_q == ST_FETCH) ? fetch_addr : 8'h00;
        tx_data   = tx_data_q;
        dbg_state = state_q;
        xfer      = tx_valid && tx_ready;
    end

    // Next-state, counter and output-byte logic.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        tx_data_d = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    row_d   = 8'h00;
                    col_d   = 8'h00;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Buffer content is captured in this cycle, so later writes
                // to an already-fetched cell do not affect the frame.
                tx_data_d = clean_byte;
                state_d   = ST_SEND_CH;
            end
            ST_SEND_CH: begin
                if (xfer) begin
                    if (col_q == LAST_COL) begin
                        tx_data_d = CR;
                        state_d   = ST_SEND_CR;
                    end else begin
                        col_d   = col_q + 8'h01;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_SEND_CR: begin
                if (xfer) begin
                    tx_data_d = LF;
                    state_d   = ST_SEND_LF;
                end
            end
            ST_SEND_LF: begin
                if (xfer) begin
                    if (row_q == LAST_ROW) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d   = row_q + 8'h01;
                        col_d   = 8'h00;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                // A start arriving here is dropped on purpose.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            row_q     <= 8'h00;
            col_q     <= 8'h00;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            tx_data_q <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: a behavioural buffer, a byte-stream reference
// model built from the buffer contents, and a transfer monitor that
// scores every accepted byte against the expected queue.
module tb_frame_reader;

    localparam int ROWS      = 8;
    localparam int COLS      = 16;
    localparam int FRAME_LEN = ROWS * (COLS + 2);
    localparam int FRAME_CYC = ROWS * (2 * COLS + 2) + 1;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       start;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic [2:0] dbg_state;

    logic [7:0] mem [0:255];
    assign rd_data = mem[rd_addr];

    frame_reader #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;
    int rx_cnt   = 0;
    int done_cnt = 0;
    bit rnd_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_char(input logic [7:0] b);
        return (b >= 8'h20 && b <= 8'h7E) ? b : 8'h2E;
    endfunction

    // Expected frame: every cell in raster order, CR LF after each row.
    task automatic build_frame();
        exp_q.delete();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                exp_q.push_back(model_char(mem[r * COLS + c]));
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic fill_mem(input bit random_fill);
        for (int i = 0; i < 256; i++) begin
            mem[i] = random_fill ? 8'($urandom_range(0, 255)) : 8'h7E;
        end
    endtask

    function automatic logic next_ready();
        return rnd_ready ? logic'($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    // Transfer monitor, sampled on the falling edge.
    bit         prev_valid = 1'b0;
    bit         prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clk) begin
        if (!mon_en || rst) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check($sformatf("byte%0d", rx_cnt), 32'(tx_data), 32'(exp_q.pop_front()));
                end
                rx_cnt++;
            end
            if (done) begin
                done_cnt++;
                check("busy_at_done", 32'(busy), 32'd0);
                check("valid_at_done", 32'(tx_valid), 32'd0);
                check("rd_addr_at_done", 32'(rd_addr), 32'd0);
            end
            check("rd_addr_range", 32'(int'(rd_addr) < ROWS * COLS), 32'd1);
            prev_valid = tx_valid;
            prev_ready = tx_ready;
            prev_data  = tx_data;
        end
    end

    // ---------------- driver ----------------
    task automatic run_frame(input bit rnd, input bit chk_cyc, input bit restart_mid,
                             input bit restart_done, input bit hook);
        int cyc;
        bit seen;
        bit hooked;
        rnd_ready = rnd;
        build_frame();
        if (hook) begin
            exp_q[(40 / COLS) * (COLS + 2) + (40 % COLS)] = model_char(8'h5A);
        end
        rx_cnt   = 0;
        done_cnt = 0;
        mon_en   = 1'b1;
        hooked   = 1'b0;
        seen     = 1'b0;
        @(posedge clk);
        #1;
        start    = 1'b1;
        tx_ready = next_ready();
        cyc      = 0;
        while (!seen && cyc < 20000) begin
            @(negedge clk);
            if (hook && !hooked && rd_addr == 8'd39) begin
                // Cell 40 changes two cycles before its fetch; cell 3 was
                // already sent and must keep its old value in this frame.
                mem[40] = 8'h5A;
                mem[3]  = 8'h55;
                hooked  = 1'b1;
            end
            if (done) begin
                seen = 1'b1;
                if (chk_cyc) check("done_cycle", 32'(cyc), 32'(FRAME_CYC));
                if (restart_done) start = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
            start    = (restart_mid && cyc == 50) ? 1'b1 : 1'b0;
            tx_ready = next_ready();
        end
        check("done_seen", 32'(seen), 32'd1);
        if (hook) check("hook_fired", 32'(hooked), 32'd1);
        repeat (6) begin
            @(negedge clk);
            check("busy_after", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            tx_ready = next_ready();
        end
        check("done_count", 32'(done_cnt), 32'd1);
        check("frame_len", 32'(rx_cnt), 32'(FRAME_LEN));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Start a frame and kill it with reset once row 3 is being read.
    task automatic abort_in_row3();
        int cyc;
        bit hit;
        rnd_ready = 1'b1;
        build_frame();
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b1;
        tx_ready = next_ready();
        hit      = 1'b0;
        cyc      = 0;
        while (!hit && cyc < 5000) begin
            @(negedge clk);
            if (int'(rd_addr) >= 3 * COLS) hit = 1'b1;
            else begin
                @(posedge clk);
                #1;
                start    = 1'b0;
                tx_ready = next_ready();
                cyc++;
            end
        end
        check("reached_row3", 32'(hit), 32'd1);
        check("busy_row3", 32'(busy), 32'd1);
        #1;
        rst    = 1'b1;
        mon_en = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("abort");
        repeat (2) begin
            @(negedge clk);
            check("abort_hold_done", 32'(done), 32'd0);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_abort_done", 32'(done), 32'd0);
            check("post_abort_busy", 32'(busy), 32'd0);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        tx_ready = 1'b0;
        fill_mem(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All-tilde buffer, downstream always ready: exact cycle count.
        run_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Printable and non-printable cells.
        mem[5]  = 8'h41;
        mem[17] = 8'h07;
        run_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Random buffer with back-pressure.
        fill_mem(1'b1);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Extra starts mid-frame and on the done cycle are ignored.
        fill_mem(1'b1);
        run_frame(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Buffer written during the frame.
        fill_mem(1'b1);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in row 3, then a clean frame from address 0.
        fill_mem(1'b1);
        abort_in_row3();
        fill_mem(1'b1);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
